// File: rtl/moore_seq_det.sv
// moore_seq_det: programmable serial sequence detector with a Moore match flag.
// Accepted bits shift into a PATTERN_W-bit history register (newest in LSB).
// A match is declared once PATTERN_W bits have been accepted since the last
// restart and the history equals the loaded pattern. The match flag is
// registered and depends only on state. A saturating counter tallies matches.
// Optional feature: define MOORE_SEQ_DET_MASK_EN to add a pattern_mask input
// and mask register; mask bits at 0 are don't-care in the comparison.
module moore_seq_det #(
    parameter int                   PATTERN_W   = 4,
    parameter int                   COUNT_W     = 8,
    parameter logic [PATTERN_W-1:0] PATTERN_RST = 4'b1011
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in,
    input  logic                 in_valid,
    input  logic [PATTERN_W-1:0] pattern,
`ifdef MOORE_SEQ_DET_MASK_EN
    input  logic [PATTERN_W-1:0] pattern_mask,
`endif
    input  logic                 pattern_load,
    input  logic                 overlap,
    input  logic                 cnt_clr,
    output logic                 out,
    output logic [COUNT_W-1:0]   match_cnt
);

    // fill counts 0..PATTERN_W inclusive, so it needs one extra code point.
    localparam int                 FILL_W  = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PATTERN_W);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic [PATTERN_W-1:0] shreg_q, shreg_d;
    logic [FILL_W-1:0]    fill_q,  fill_d;
    logic [PATTERN_W-1:0] pat_q,   pat_d;
    logic                 out_q,   out_d;
    logic [COUNT_W-1:0]   cnt_q,   cnt_d;

    logic [PATTERN_W-1:0] shreg_n;
    logic [FILL_W-1:0]    fill_n;
    logic [PATTERN_W-1:0] cmp_mask;
    logic                 hit;

`ifdef MOORE_SEQ_DET_MASK_EN
    logic [PATTERN_W-1:0] mask_q, mask_d;
    assign cmp_mask = mask_q;
`else
    assign cmp_mask = '1;
`endif

    // Next-state of the history/fill pair if the current bit were accepted,
    // and whether that accepted bit would complete a match.
    always_comb begin
        shreg_n = {shreg_q[PATTERN_W-2:0], in};
        fill_n  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        hit     = (fill_n == FILL_FULL) &&
                  ((shreg_n & cmp_mask) == (pat_q & cmp_mask));
    end

    // Register update: load beats an accepted bit; counter clear beats increment.
    always_comb begin
        shreg_d = shreg_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
`ifdef MOORE_SEQ_DET_MASK_EN
        mask_d  = mask_q;
`endif
        if (pattern_load) begin
            // Restart detection with the new pattern; any bit this cycle is dropped.
            pat_d   = pattern;
`ifdef MOORE_SEQ_DET_MASK_EN
            mask_d  = pattern_mask;
`endif
            shreg_d = '0;
            fill_d  = '0;
            out_d   = 1'b0;
        end else if (in_valid) begin
            shreg_d = shreg_n;
            out_d   = hit;
            // Non-overlap mode discards the matched bits by restarting fill;
            // the history itself still shifts.
            fill_d  = (hit && !overlap) ? '0 : fill_n;
            if (hit && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + COUNT_W'(1);
            end
        end
        if (cnt_clr) begin
            cnt_d = '0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            fill_q  <= '0;
            pat_q   <= PATTERN_RST;
            out_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef MOORE_SEQ_DET_MASK_EN
            mask_q  <= '1;
`endif
        end else begin
            shreg_q <= shreg_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
`ifdef MOORE_SEQ_DET_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign out       = out_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_moore_seq_det.sv
// Bench for moore_seq_det: directed scenarios plus randomized traffic, checked
// against a queue-based reference model of the detection rules. Two instances
// share all inputs: a default 8-bit counter and a 2-bit counter for saturation.
module tb_moore_seq_det;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_b;
    logic         in_valid;
    logic [W-1:0] pattern;
    logic         pattern_load;
    logic         overlap;
    logic         cnt_clr;
    logic         out_a, out_s;
    logic [7:0]   cnt_a;
    logic [1:0]   cnt_s;
`ifdef MOORE_SEQ_DET_MASK_EN
    logic [W-1:0] mask_all = '1;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: bits accepted since the last restart (oldest first).
    bit           hist[$];
    logic [W-1:0] m_pat;
    bit           m_out;
    int           m_cnt8;
    int           m_cnt2;

    always #5 clk = ~clk;

    moore_seq_det #(.PATTERN_W(W), .COUNT_W(8), .PATTERN_RST(4'b1011)) dut (
        .clk(clk), .reset(reset), .in(in_b), .in_valid(in_valid),
        .pattern(pattern),
`ifdef MOORE_SEQ_DET_MASK_EN
        .pattern_mask(mask_all),
`endif
        .pattern_load(pattern_load), .overlap(overlap), .cnt_clr(cnt_clr),
        .out(out_a), .match_cnt(cnt_a)
    );

    moore_seq_det #(.PATTERN_W(W), .COUNT_W(2), .PATTERN_RST(4'b1011)) dut_s (
        .clk(clk), .reset(reset), .in(in_b), .in_valid(in_valid),
        .pattern(pattern),
`ifdef MOORE_SEQ_DET_MASK_EN
        .pattern_mask(mask_all),
`endif
        .pattern_load(pattern_load), .overlap(overlap), .cnt_clr(cnt_clr),
        .out(out_s), .match_cnt(cnt_s)
    );

    task automatic model_reset();
        hist.delete();
        m_pat  = 4'b1011;
        m_out  = 1'b0;
        m_cnt8 = 0;
        m_cnt2 = 0;
    endtask

    task automatic model_update(input bit b, input bit v, input bit ld,
                                input logic [W-1:0] p, input bit clr, input bit ov);
        bit hit;
        if (ld) begin
            m_pat = p;
            hist.delete();
            m_out = 1'b0;
        end else if (v) begin
            hist.push_back(b);
            if (hist.size() > W) void'(hist.pop_front());
            hit = (hist.size() == W);
            for (int i = 0; i < W; i++)
                if (hist.size() == W && hist[i] != m_pat[W-1-i]) hit = 1'b0;
            m_out = hit;
            if (hit) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
                if (!ov) hist.delete();
            end
        end
        if (clr) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end
    endtask

    // Apply one cycle of inputs, clock it, update the model, sample at edge+1.
    task automatic step(input bit b, input bit v, input bit ld,
                        input logic [W-1:0] p, input bit clr);
        in_b = b; in_valid = v; pattern_load = ld; pattern = p; cnt_clr = clr;
        @(posedge clk);
        model_update(b, v, ld, p, clr, overlap);
        #1;
        in_valid = 1'b0; pattern_load = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in_b = 0; in_valid = 0; pattern = '0; pattern_load = 0; overlap = 1; cnt_clr = 0;
        reset = 1'b1;
        model_reset();
        #3;
        n_cmp++; if (out_a !== 1'b0) begin n_fail++; $display("FAIL reset_out got %b want 0", out_a); end
        n_cmp++; if (cnt_a !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", cnt_a); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_overlap_on();
        bit seq[7] = '{1, 0, 1, 1, 0, 1, 1};
        bit exp[7] = '{0, 0, 0, 1, 0, 0, 1};
        pulse_reset();
        overlap = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(seq[i], 1, 0, '0, 0);
            n_cmp++;
            if (out_a !== exp[i] || out_a !== m_out) begin
                n_fail++; $display("FAIL ovl_out bit%0d got %b want %b", i + 1, out_a, exp[i]);
            end
        end
        n_cmp++; if (cnt_a !== 8'd2) begin n_fail++; $display("FAIL ovl_cnt got %0d want 2", cnt_a); end
    endtask

    task automatic test_overlap_off();
        bit seq[7] = '{1, 0, 1, 1, 0, 1, 1};
        bit exp[7] = '{0, 0, 0, 1, 0, 0, 0};
        pulse_reset();
        overlap = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(seq[i], 1, 0, '0, 0);
            n_cmp++;
            if (out_a !== exp[i] || out_a !== m_out) begin
                n_fail++; $display("FAIL novl_out bit%0d got %b want %b", i + 1, out_a, exp[i]);
            end
        end
        n_cmp++; if (cnt_a !== 8'd1) begin n_fail++; $display("FAIL novl_cnt got %0d want 1", cnt_a); end
        overlap = 1'b1;
    endtask

    task automatic test_gap();
        pulse_reset();
        step(1, 1, 0, '0, 0); step(0, 1, 0, '0, 0); step(1, 1, 0, '0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, '0, 0);
            n_cmp++; if (out_a !== 1'b0) begin n_fail++; $display("FAIL gap_low c%0d got %b want 0", i, out_a); end
        end
        step(1, 1, 0, '0, 0);
        n_cmp++; if (out_a !== 1'b1) begin n_fail++; $display("FAIL gap_rise got %b want 1", out_a); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, '0, 0);
            n_cmp++; if (out_a !== 1'b1) begin n_fail++; $display("FAIL gap_hold c%0d got %b want 1", i, out_a); end
        end
    endtask

    task automatic test_load();
        bit seq[4] = '{0, 1, 1, 0};
        bit exp[4] = '{0, 0, 0, 1};
        int c0;
        step(1, 1, 0, '0, 0); step(0, 1, 0, '0, 0); step(1, 1, 0, '0, 0);
        c0 = m_cnt8;
        step(1, 1, 1, 4'b0110, 0);
        n_cmp++; if (out_a !== 1'b0) begin n_fail++; $display("FAIL load_out got %b want 0", out_a); end
        n_cmp++; if (cnt_a !== 8'(c0)) begin n_fail++; $display("FAIL load_cnt got %0d want %0d", cnt_a, c0); end
        for (int i = 0; i < 4; i++) begin
            step(seq[i], 1, 0, '0, 0);
            n_cmp++;
            if (out_a !== exp[i]) begin
                n_fail++; $display("FAIL load_seq bit%0d got %b want %b", i + 1, out_a, exp[i]);
            end
        end
        n_cmp++; if (cnt_a !== 8'(c0 + 1)) begin n_fail++; $display("FAIL load_inc got %0d want %0d", cnt_a, c0 + 1); end
    endtask

    task automatic test_saturate();
        bit exp[6] = '{0, 0, 0, 1, 1, 1};
        overlap = 1'b1;
        step(0, 0, 1, 4'b1111, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, '0, 0);
            n_cmp++;
            if (out_s !== exp[i]) begin
                n_fail++; $display("FAIL sat_out bit%0d got %b want %b", i + 1, out_s, exp[i]);
            end
        end
        n_cmp++; if (cnt_s !== 2'd3) begin n_fail++; $display("FAIL sat_cnt got %0d want 3", cnt_s); end
        step(1, 1, 0, '0, 1);
        n_cmp++; if (cnt_s !== 2'd0 || cnt_a !== 8'd0) begin
            n_fail++; $display("FAIL clr_cnt got %0d/%0d want 0/0", cnt_s, cnt_a); end
        n_cmp++; if (out_s !== 1'b1) begin n_fail++; $display("FAIL clr_out got %b want 1", out_s); end
        for (int i = 0; i < 4; i++) step(1, 1, 0, '0, 0);
        n_cmp++; if (cnt_s !== 2'd3) begin n_fail++; $display("FAIL sat_nowrap got %0d want 3", cnt_s); end
        n_cmp++; if (cnt_a !== 8'd4) begin n_fail++; $display("FAIL cnt8_after got %0d want 4", cnt_a); end
    endtask

    task automatic test_mid_reset();
        // Give the design a non-reset pattern and a nonzero count first.
        step(0, 0, 1, 4'b0110, 0);
        step(1, 1, 0, '0, 0); step(0, 1, 0, '0, 0); step(1, 1, 0, '0, 0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (out_a !== 1'b0) begin n_fail++; $display("FAIL mrst_out got %b want 0", out_a); end
        n_cmp++; if (cnt_a !== 8'd0) begin n_fail++; $display("FAIL mrst_cnt got %0d want 0", cnt_a); end
        @(negedge clk);
        reset = 1'b0;
        step(1, 1, 0, '0, 0);
        n_cmp++; if (out_a !== 1'b0) begin n_fail++; $display("FAIL mrst_nomatch got %b want 0", out_a); end
        step(0, 1, 0, '0, 0); step(1, 1, 0, '0, 0); step(1, 1, 0, '0, 0);
        n_cmp++; if (out_a !== 1'b1) begin n_fail++; $display("FAIL mrst_match got %b want 1", out_a); end
        n_cmp++; if (cnt_a !== 8'd1) begin n_fail++; $display("FAIL mrst_cnt1 got %0d want 1", cnt_a); end
    endtask

    task automatic test_random();
        bit b, v, ld, clr;
        logic [W-1:0] p;
        for (int i = 0; i < 600; i++) begin
            b   = 1'($urandom);
            v   = ($urandom % 4) != 0;
            ld  = ($urandom % 60) == 0;
            clr = ($urandom % 80) == 0;
            p   = W'($urandom);
            if (($urandom % 25) == 0) overlap = ~overlap;
            step(b, v, ld, p, clr);
            n_cmp++;
            if (out_a !== m_out || out_s !== m_out || cnt_a !== 8'(m_cnt8) || cnt_s !== 2'(m_cnt2)) begin
                n_fail++;
                $display("FAIL rand c%0d out %b/%b cnt %0d/%0d want out %b cnt %0d/%0d",
                         i, out_a, out_s, cnt_a, cnt_s, m_out, m_cnt8, m_cnt2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap_on();
        test_overlap_off();
        test_gap();
        test_load();
        test_saturate();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
